xc_sha256_fu: RTL and testbench
===============================

// Module: xc_sha256_fu
// PURPOSE
//  Execute-stage functional unit for the SHA-256 sigma instructions xc.sha256.s0/s1/s2/s3.
//  Takes decoded op + rs1 value from dispatch over a valid/ready handshake.
//  Returns the 32-bit result, with its rd tag, to writeback over a second valid/ready handshake.
//  Two-stage pipeline (rotate stage, XOR/merge stage); writeback zeroes the result for rd==x0.
// PARAMETERS
//  TAG_W     5  width of the opaque tag (rd address) carried alongside each op
//  OUT_SKID  1  1: 1-entry skid buffer on the output, so in_ready has no comb path from out_ready; 0: none
// PORTS
//  g_clk      in   1      clock; all state updates on rising edge
//  g_resetn   in   1      synchronous reset, active-low
//  flush      in   1      kill all in-flight ops (pipeline flush from CPU)
//  in_valid   in   1      dispatch presents an op
//  in_ready   out  1      unit accepts op this cycle
//  in_op      in   4      one-hot {s3,s2,s1,s0}
//  in_rs1     in   32     source operand
//  in_tag     in   TAG_W  passed through unchanged
//  out_valid  out  1      result available
//  out_ready  in   1      writeback consumes result
//  out_result out  32     sigma result
//  out_tag    out  TAG_W  tag of result
//  out_err    out  1      op was not one-hot; result forced to 0
// BEHAVIOUR
//  Functions (ROR = rotate right, SHR = logical shift right):
//   s0 = ROR7^ROR18^SHR3;  s1 = ROR17^ROR19^SHR10;  s2 = ROR2^ROR13^ROR22;  s3 = ROR6^ROR11^ROR25
//  Stage 1 (accept on in_valid&&in_ready):
//   registers the three selected shifted terms t0,t1,t2 (3x32), tag, err, v1.
//  Stage 2:
//   registers t0^t1^t2 (0 if err), tag, err, v2.
//  Latency and throughput:
//   latency 2 cycles accept->out_valid when unstalled; throughput 1 op/cycle.
//  Stall rule:
//   stage k advances iff its downstream is empty or advancing.
//   Without skid: in_ready = !v1 || (!v2 || out_ready).
//  Skid (OUT_SKID=1):
//   when out_ready falls, the result that would be lost is captured in the skid entry.
//   The output presents the skid entry first; in_ready is a registered function of skid occupancy.
//  Output hold:
//   out_result/out_tag/out_err stable while out_valid && !out_ready.
//  Illegal op:
//   in_op==0 or >1 bit set -> out_err=1, out_result=0, op still completes in order.
//  Flush:
//   same-cycle clear of v1, v2 and skid valid.
//   in_ready=0 during flush; an op presented with flush is dropped.
//   Data registers are not cleared.
//  Reset (g_resetn low at edge):
//   v1=v2=skid_valid=0, out_valid=0, out_result=0, out_tag=0, out_err=0.
//   in_ready=0 during reset, 1 from the first cycle after.
//   Reset mid-op discards everything.
//  Simultaneous events:
//   accept + emit in the same cycle is legal and preserves order.
//   flush wins over accept/emit.
//   out_valid never asserts for a flushed op.
//  No combinational path in_* -> out_*.
// STRUCTURE
//  Package xc_sha256_pkg:
//   op one-hot index localparams (OP_S0..OP_S3)
//   rotation/shift amount constants for each function
//   function sha256_terms(op, rs1) -> 3x32
//  Sub-module xc_pipe_skid:
//   generic 1-entry valid/ready skid register, TAG_W+33 bits payload.
//   Reused from the output buffer; instantiated only when OUT_SKID=1.
// TESTING
//  1. rs1=0x00000001, op=s2, out_ready=1 -> out_result=0x40080400 two cycles after accept, out_err=0.
//  2. rs1=0x00000001 with ops s0,s1,s3 back-to-back -> 0x02004000, 0x0000A000, 0x04200080 in order on 3 consecutive cycles.
//  3. rs1=0xFFFFFFFF op=s2 -> 0xFFFFFFFF; op=s0 -> 0x1FFFFFFF (SHR path zero-fills).
//  4. Hold out_ready=0 for 5 cycles with 3 ops issued -> in_ready drops.
//     Outputs stable, no loss/duplication, tags 1,2,3 emerge in order on release.
//  5. flush with 2 ops in flight plus one presented -> none emerge, next op after flush returns correct result.
//  6. in_op=4'b0110 -> out_err=1, out_result=0.
//     g_resetn low mid-op -> all outputs 0 next cycle, no stale out_valid.

Source files
------------

// File: rtl/xc_sha256_pkg.sv
// Shared constants and the sigma term generator for the xc.sha256.s0..s3 unit.
// Each function is the XOR of three shifted copies of rs1; only the shift amounts differ.
package xc_sha256_pkg;

    localparam int OP_W  = 4;
    localparam int OP_S0 = 0;
    localparam int OP_S1 = 1;
    localparam int OP_S2 = 2;
    localparam int OP_S3 = 3;

    localparam int S0_ROR_A = 7;
    localparam int S0_ROR_B = 18;
    localparam int S0_SHR_C = 3;
    localparam int S1_ROR_A = 17;
    localparam int S1_ROR_B = 19;
    localparam int S1_SHR_C = 10;
    localparam int S2_ROR_A = 2;
    localparam int S2_ROR_B = 13;
    localparam int S2_ROR_C = 22;
    localparam int S3_ROR_A = 6;
    localparam int S3_ROR_B = 11;
    localparam int S3_ROR_C = 25;

    typedef logic [31:0]      word_t;
    typedef logic [2:0][31:0] terms_t;

    typedef struct packed {
        logic  err;
        word_t result;
    } merge_t;

    function automatic word_t ror32(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Illegal (non-one-hot) ops yield all-zero terms; the merge stage also forces 0 on err.
    function automatic terms_t sha256_terms(input logic [OP_W-1:0] op, input word_t rs1);
        terms_t t;
        t = '0;
        if (op == (OP_W'(1) << OP_S0)) begin
            t[0] = ror32(rs1, S0_ROR_A);
            t[1] = ror32(rs1, S0_ROR_B);
            t[2] = rs1 >> S0_SHR_C;
        end else if (op == (OP_W'(1) << OP_S1)) begin
            t[0] = ror32(rs1, S1_ROR_A);
            t[1] = ror32(rs1, S1_ROR_B);
            t[2] = rs1 >> S1_SHR_C;
        end else if (op == (OP_W'(1) << OP_S2)) begin
            t[0] = ror32(rs1, S2_ROR_A);
            t[1] = ror32(rs1, S2_ROR_B);
            t[2] = ror32(rs1, S2_ROR_C);
        end else if (op == (OP_W'(1) << OP_S3)) begin
            t[0] = ror32(rs1, S3_ROR_A);
            t[1] = ror32(rs1, S3_ROR_B);
            t[2] = ror32(rs1, S3_ROR_C);
        end
        return t;
    endfunction

endpackage

// File: rtl/xc_sha256_fu_if.sv
// Dispatch-side and writeback-side handshakes of the SHA-256 sigma unit.
// master = CPU (dispatch + writeback), slave = the functional unit.
interface xc_sha256_fu_if
    import xc_sha256_pkg::*;
#(
    parameter int TAG_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [31:0]     in_rs1;
    logic [TAG_W-1:0] in_tag;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic            out_err;

    modport master (
        output in_valid, in_op, in_rs1, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_err
    );
endinterface

// File: rtl/xc_pipe_skid.sv
// Generic 1-entry valid/ready skid register. Upstream data passes straight through
// while the entry is empty; a beat refused downstream is parked and presented first.
module xc_pipe_skid #(
    parameter int W = 38
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         skid_valid_reg;
    logic [W-1:0] skid_data_reg;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else if (flush) begin
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            if (out_ready) begin
                skid_valid_reg <= 1'b0;
            end
        end else if (in_valid && !out_ready) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
        end
    end

    // Readiness depends only on the register, which breaks the out_ready -> in_ready path.
    assign in_ready  = !skid_valid_reg;
    assign out_valid = skid_valid_reg || in_valid;
    assign out_data  = skid_valid_reg ? skid_data_reg : in_data;

endmodule

// File: rtl/xc_sha256_fu.sv
// Two-stage execute unit for xc.sha256.s0..s3: stage 1 registers the three shifted
// terms, stage 2 registers their XOR; results return in order with the rd tag.
module xc_sha256_fu
    import xc_sha256_pkg::*;
#(
    parameter int TAG_W    = 5,
    parameter bit OUT_SKID = 1'b1
) (
    input  logic           g_clk,
    input  logic           g_resetn,
    input  logic           flush,
    xc_sha256_fu_if.slave  io
);
    localparam int PW = TAG_W + 33;

    terms_t           t_reg;
    logic [TAG_W-1:0] tag1_reg;
    logic             err1_reg;
    logic             v1_reg;

    merge_t           m2_reg;
    logic [TAG_W-1:0] tag2_reg;
    logic             v2_reg;

    terms_t t_next;
    word_t  xor_next;
    merge_t m2_next;
    logic   op_err;
    logic   down_ready;
    logic   adv1;
    logic   adv2;
    logic   accept;

    // A stage advances when the stage after it is empty or itself advancing.
    assign adv2        = !v2_reg || down_ready;
    assign adv1        = !v1_reg || adv2;
    assign io.in_ready = g_resetn && !flush && adv1;
    assign accept      = io.in_valid && io.in_ready;

    assign op_err = !$onehot(io.in_op);
    assign t_next = sha256_terms(io.in_op, io.in_rs1);

    for (genvar gi = 0; gi < 32; gi++) begin : g_merge
        assign xor_next[gi] = t_reg[0][gi] ^ t_reg[1][gi] ^ t_reg[2][gi];
    end

    assign m2_next.err    = err1_reg;
    assign m2_next.result = err1_reg ? 32'h0 : xor_next;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            t_reg    <= '0;
            tag1_reg <= '0;
            err1_reg <= 1'b0;
            v1_reg   <= 1'b0;
            m2_reg   <= '0;
            tag2_reg <= '0;
            v2_reg   <= 1'b0;
        end else begin
            if (flush) begin
                v1_reg <= 1'b0;
                v2_reg <= 1'b0;
            end else begin
                if (adv1) begin
                    v1_reg <= accept;
                end
                if (adv2) begin
                    v2_reg <= v1_reg;
                end
            end
            if (accept) begin
                t_reg    <= t_next;
                tag1_reg <= io.in_tag;
                err1_reg <= op_err;
            end
            if (adv2 && v1_reg) begin
                m2_reg   <= m2_next;
                tag2_reg <= tag1_reg;
            end
        end
    end

    if (OUT_SKID) begin : g_skid
        logic          skid_out_valid;
        logic [PW-1:0] skid_out_data;

        xc_pipe_skid #(
            .W (PW)
        ) u_skid (
            .g_clk     (g_clk),
            .g_resetn  (g_resetn),
            .flush     (flush),
            .in_valid  (v2_reg),
            .in_ready  (down_ready),
            .in_data   ({tag2_reg, m2_reg.err, m2_reg.result}),
            .out_valid (skid_out_valid),
            .out_ready (io.out_ready),
            .out_data  (skid_out_data)
        );

        // A flush kills the op on the output this cycle as well.
        assign io.out_valid = skid_out_valid && !flush;
        assign {io.out_tag, io.out_err, io.out_result} = skid_out_data;
    end else begin : g_noskid
        assign down_ready    = io.out_ready;
        assign io.out_valid  = v2_reg && !flush;
        assign io.out_tag    = tag2_reg;
        assign io.out_err    = m2_reg.err;
        assign io.out_result = m2_reg.result;
    end

endmodule

// File: tb/tb_xc_sha256_fu.sv
// Directed bench for xc_sha256_fu: a scoreboard of sigma results computed from the
// textbook formulas, checked every cycle, plus literal expectations per scenario.
module tb_xc_sha256_fu;
    logic g_clk;
    logic g_resetn;
    logic flush;

    xc_sha256_fu_if #(.TAG_W(5)) bus ();

    xc_sha256_fu #(
        .TAG_W    (5),
        .OUT_SKID (1'b1)
    ) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .flush    (flush),
        .io       (bus)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        err;
        int          cyc;
    } emit_t;

    exp_t  sb[$];
    emit_t emit_log[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [4:0] tag);
        exp_t e;
        e.tag = tag;
        e.err = 1'b0;
        case (op)
            4'b0001: e.res = rotr(x, 7)  ^ rotr(x, 18) ^ (x >> 3);
            4'b0010: e.res = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
            4'b0100: e.res = rotr(x, 2)  ^ rotr(x, 13) ^ rotr(x, 22);
            4'b1000: e.res = rotr(x, 6)  ^ rotr(x, 11) ^ rotr(x, 25);
            default: begin e.res = 32'h0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    always @(posedge g_clk) cyc <= cyc + 1;

    logic        rst_prev  = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_res;
    logic [4:0]  hold_tag;
    logic        hold_err;

    // Sampled mid-cycle: what is seen here is what the next rising edge acts on.
    always @(negedge g_clk) begin
        if (rst_prev) begin
            chk("rst_out_valid",  32'(bus.out_valid), 32'h0);
            chk("rst_out_result", bus.out_result,     32'h0);
            chk("rst_out_tag",    32'(bus.out_tag),   32'h0);
            chk("rst_out_err",    32'(bus.out_err),   32'h0);
        end
        if (!g_resetn || flush) chk("in_ready_blocked", 32'(bus.in_ready), 32'h0);
        if (flush) chk("valid_during_flush", 32'(bus.out_valid), 32'h0);
        if (hold_prev) begin
            chk("hold_valid",  32'(bus.out_valid), 32'h1);
            chk("hold_result", bus.out_result,     hold_res);
            chk("hold_tag",    32'(bus.out_tag),   32'(hold_tag));
            chk("hold_err",    32'(bus.out_err),   32'(hold_err));
        end
        if (bus.out_valid && g_resetn && !flush) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(bus.out_valid), 32'h0);
            end else begin
                chk("sb_result", bus.out_result,   sb[0].res);
                chk("sb_tag",    32'(bus.out_tag), 32'(sb[0].tag));
                chk("sb_err",    32'(bus.out_err), 32'(sb[0].err));
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                    emit_log.push_back('{bus.out_result, bus.out_tag, bus.out_err, cyc});
                end
            end
        end
        hold_prev <= bus.out_valid && !bus.out_ready && g_resetn && !flush;
        hold_res  <= bus.out_result;
        hold_tag  <= bus.out_tag;
        hold_err  <= bus.out_err;
        rst_prev  <= !g_resetn;
        if (!g_resetn || flush) sb.delete();
        else if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_op, bus.in_rs1, bus.in_tag));
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] rs1, input logic [4:0] tag,
                         output int acc);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = rs1;
        bus.in_tag   = tag;
        acc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge g_clk);
            if (bus.in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("issue_timeout", 32'(bus.in_ready), 32'h1);
        $display("issue tag=%0d op=%b rs1=%h accepted_cycle=%0d", tag, op, rs1, acc);
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_emits(input int n, input string name);
        for (int k = 0; k < 50 && emit_log.size() < n; k++) @(posedge g_clk);
        repeat (4) @(posedge g_clk);
        #1;
        chk(name, 32'(emit_log.size()), 32'(n));
    endtask

    task automatic log_chk(input int i, input logic [31:0] res, input logic [4:0] tag, input logic err);
        if (i >= emit_log.size()) begin
            chk("log_missing", 32'(emit_log.size()), 32'(i + 1));
        end else begin
            $display("result tag=%0d result=%h err=%0d cycle=%0d",
                     emit_log[i].tag, emit_log[i].res, emit_log[i].err, emit_log[i].cyc);
            chk("lit_result", emit_log[i].res,       res);
            chk("lit_tag",    32'(emit_log[i].tag),  32'(tag));
            chk("lit_err",    32'(emit_log[i].err),  32'(err));
        end
    endtask

    initial begin
        int acc;
        g_resetn      = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'b0;
        bus.in_rs1    = 32'h0;
        bus.in_tag    = 5'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        @(negedge g_clk);
        chk("post_rst_in_ready",  32'(bus.in_ready),  32'h1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("post_rst_result",    bus.out_result,     32'h0);
        @(posedge g_clk);
        #1;

        // Single s2 op: result two cycles after accept.
        emit_log.delete();
        issue(4'b0100, 32'h1, 5'd5, acc);
        idle();
        wait_emits(1, "t1_count");
        log_chk(0, 32'h40080400, 5'd5, 1'b0);
        if (emit_log.size() > 0) chk("t1_latency", 32'(emit_log[0].cyc - acc), 32'd2);

        // Back-to-back s0, s1, s3.
        emit_log.delete();
        issue(4'b0001, 32'h1, 5'd6, acc);
        issue(4'b0010, 32'h1, 5'd7, acc);
        issue(4'b1000, 32'h1, 5'd8, acc);
        idle();
        wait_emits(3, "t2_count");
        log_chk(0, 32'h02004000, 5'd6, 1'b0);
        log_chk(1, 32'h0000A000, 5'd7, 1'b0);
        log_chk(2, 32'h04200080, 5'd8, 1'b0);
        if (emit_log.size() == 3) begin
            chk("t2_consec_a", 32'(emit_log[1].cyc - emit_log[0].cyc), 32'd1);
            chk("t2_consec_b", 32'(emit_log[2].cyc - emit_log[1].cyc), 32'd1);
        end

        // All-ones operand: rotates keep ones, SHR zero-fills.
        emit_log.delete();
        issue(4'b0100, 32'hFFFFFFFF, 5'd20, acc);
        issue(4'b0001, 32'hFFFFFFFF, 5'd21, acc);
        idle();
        wait_emits(2, "t3_count");
        log_chk(0, 32'hFFFFFFFF, 5'd20, 1'b0);
        log_chk(1, 32'h1FFFFFFF, 5'd21, 1'b0);

        // Backpressure: three ops fill the unit, a fourth waits.
        emit_log.delete();
        bus.out_ready = 1'b0;
        issue(4'b0001, 32'h1, 5'd1, acc);
        issue(4'b0010, 32'h1, 5'd2, acc);
        issue(4'b0100, 32'h1, 5'd3, acc);
        bus.in_op  = 4'b0100;
        bus.in_rs1 = 32'hFFFFFFFF;
        bus.in_tag = 5'd4;
        repeat (5) begin
            @(negedge g_clk);
            chk("t4_in_ready_low", 32'(bus.in_ready),  32'h0);
            chk("t4_valid_high",   32'(bus.out_valid), 32'h1);
            chk("t4_head_tag",     32'(bus.out_tag),   32'd1);
        end
        @(posedge g_clk);
        #1;
        bus.out_ready = 1'b1;
        issue(4'b0100, 32'hFFFFFFFF, 5'd4, acc);
        idle();
        wait_emits(4, "t4_count");
        log_chk(0, 32'h02004000, 5'd1, 1'b0);
        log_chk(1, 32'h0000A000, 5'd2, 1'b0);
        log_chk(2, 32'h40080400, 5'd3, 1'b0);
        log_chk(3, 32'hFFFFFFFF, 5'd4, 1'b0);

        // Flush with two in flight and one presented.
        emit_log.delete();
        issue(4'b0100, 32'h1, 5'd9, acc);
        issue(4'b0100, 32'h1, 5'd10, acc);
        bus.in_tag = 5'd11;
        flush = 1'b1;
        @(negedge g_clk);
        chk("t5_flush_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        idle();
        repeat (6) @(posedge g_clk);
        #1;
        chk("t5_none_emerged", 32'(emit_log.size()), 32'h0);
        issue(4'b1000, 32'h1, 5'd12, acc);
        idle();
        wait_emits(1, "t5_after_count");
        log_chk(0, 32'h04200080, 5'd12, 1'b0);

        // Illegal ops.
        emit_log.delete();
        issue(4'b0110, 32'h12345678, 5'd13, acc);
        issue(4'b0000, 32'hFFFFFFFF, 5'd14, acc);
        idle();
        wait_emits(2, "t6_count");
        log_chk(0, 32'h0, 5'd13, 1'b1);
        log_chk(1, 32'h0, 5'd14, 1'b1);

        // Reset with an op in flight.
        emit_log.delete();
        issue(4'b0001, 32'h1, 5'd15, acc);
        idle();
        g_resetn = 1'b0;
        @(negedge g_clk);
        chk("t6_rst_in_ready", 32'(bus.in_ready), 32'h0);
        @(negedge g_clk);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_rst_tag",   32'(bus.out_tag),   32'h0);
        chk("t6_rst_err",   32'(bus.out_err),   32'h0);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        repeat (6) @(posedge g_clk);
        #1;
        chk("t6_no_stale", 32'(emit_log.size()), 32'h0);
        issue(4'b0010, 32'hFFFFFFFF, 5'd16, acc);
        idle();
        wait_emits(1, "t6_recover_count");
        log_chk(0, 32'h003FFFFF, 5'd16, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
